// File: rtl/uart_load_ctrl.sv
// Frame controller behind the UART receiver: parses a one-word header, then streams
// payload words into the selected on-chip buffer and reports completion or error.
module uart_load_ctrl #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       rx_data,
  input  logic              rx_valid,
  input  logic              cnn_busy,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rx_valid_q, rx_valid_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              load_done_q, load_done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic        acc;
  logic [1:0]  hdr_sel;
  logic [11:0] hdr_n;
  logic        n_too_big;

  assign acc       = rx_valid & ~rx_valid_q;
  assign hdr_sel   = rx_data[15:14];
  assign hdr_n     = rx_data[11:0];
  assign n_too_big = (32'(hdr_n) >> ADDR_W) != 32'd0;

  always_comb begin
    state_d     = state_q;
    rx_valid_d  = rx_valid;
    rem_d       = rem_q;
    next_addr_d = next_addr_q;
    to_cnt_d    = to_cnt_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (cnn_busy) begin
            err_d = 1'b1; err_code_d = 2'd0;
          end else if (hdr_n == 12'd0) begin
            err_d = 1'b1; err_code_d = 2'd1;
          end else if (hdr_sel == 2'd3) begin
            err_d = 1'b1; err_code_d = 2'd2;
          end else if (n_too_big) begin
            err_d = 1'b1; err_code_d = 2'd3;
          end else begin
            mem_sel_d   = hdr_sel;
            rem_d       = ADDR_W'(hdr_n);
            next_addr_d = '0;
            to_cnt_d    = 16'd0;
            state_d     = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = next_addr_q;
          mem_wdata_d = rx_data;
          next_addr_d = next_addr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          to_cnt_d    = 16'd0;
          if (rem_q == ADDR_W'(1)) state_d = S_DONE;
        end else if (to_cnt_q >= TIMEOUT) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        // rx_valid_q may fall but not rise here, so an edge arriving in DONE
        // is still seen in IDLE if the level is held.
        rx_valid_d = rx_valid & rx_valid_q;
        if (!load_done_q) load_done_d = 1'b1;
        else              state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b0;
      rem_q       <= '0;
      next_addr_q <= '0;
      to_cnt_q    <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'd0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      rem_q       <= rem_d;
      next_addr_q <= next_addr_d;
      to_cnt_q    <= to_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign load_done = load_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Scoreboard bench for uart_load_ctrl: a frame-level model queues expected write,
// done and error events; a negedge monitor pops and compares each DUT event.
module tb_uart_load_ctrl;
  localparam int          ADDR_W  = 12;
  localparam logic [15:0] TIMEOUT = 16'd40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       rx_data = 16'd0;
  logic              rx_valid = 1'b0;
  logic              cnn_busy = 1'b0;
  logic              mem_we;
  logic [1:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy, load_done, err;
  logic [1:0]        err_code;

  uart_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cnn_busy(cnn_busy), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .load_done(load_done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [33:0] exp_q[$];
  logic [15:0] pay[0:15];

  // event = {kind, sel, code, addr[11:0], data}; kind 1 write, 2 done, 3 err
  function automatic logic [33:0] ev(input logic [1:0] kind, input logic [1:0] sel,
                                     input logic [1:0] code, input logic [11:0] addr,
                                     input logic [15:0] data);
    return {kind, sel, code, addr, data};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [33:0] act;
    if (rst_n && (mem_we || load_done || err)) begin
      if (err)            act = ev(2'd3, 2'd0, err_code, 12'd0, 16'd0);
      else if (load_done) act = ev(2'd2, mem_sel, 2'd0, 12'd0, 16'd0);
      else                act = ev(2'd1, mem_sel, 2'd0, 12'(mem_addr), mem_wdata);
      if (exp_q.size() == 0) chk("unexpected_event", 64'(act), 64'h0);
      else chk("event", 64'(act), 64'(exp_q.pop_front()));
    end
  end

  task automatic send_word(input logic [15:0] d, input int hold);
    @(posedge clk); #1;
    rx_data = d; rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("idle_within_budget", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  // Frame-level model: decides the header outcome from its fields, queues the
  // expected events, then drives the words. abort = a reset follows the sent words.
  task automatic send_frame(input logic [15:0] hdr, input int nsend, input int hold,
                            input bit abort);
    int n = int'(hdr[11:0]);
    logic [1:0] sel = hdr[15:14];
    int code = -1;
    if (cnn_busy)              code = 0;
    else if (n == 0)           code = 1;
    else if (sel == 2'd3)      code = 2;
    else if (n >= (1 << ADDR_W)) code = 3;
    if (code >= 0) begin
      exp_q.push_back(ev(2'd3, 2'd0, 2'(code), 12'd0, 16'd0));
      send_word(hdr, hold);
      chk("busy_after_bad_header", 64'(busy), 64'd0);
      return;
    end
    for (int i = 0; i < nsend && i < n; i++)
      exp_q.push_back(ev(2'd1, sel, 2'd0, 12'(i), pay[i]));
    if (!abort) begin
      if (nsend < n) exp_q.push_back(ev(2'd3, 2'd0, 2'd3, 12'd0, 16'd0));
      else           exp_q.push_back(ev(2'd2, sel, 2'd0, 12'd0, 16'd0));
    end
    send_word(hdr, hold);
    chk("busy_after_header", 64'(busy), 64'd1);
    for (int i = 0; i < nsend; i++) send_word(pay[i], hold);
    if (!abort) wait_idle(int'(TIMEOUT) + 100);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({mem_we, mem_sel, mem_addr, mem_wdata, busy, load_done, err, err_code}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    pay[0] = 16'hA5A5; pay[1] = 16'h0001; pay[2] = 16'hFFFF;
    send_frame(16'h4003, 3, 1, 1'b0);
    send_frame(16'h0000, 0, 1, 1'b0);
    send_frame(16'hC002, 0, 1, 1'b0);
    chk("err_code_held", 64'(err_code), 64'd2);

    pay[0] = 16'h1234;
    send_frame(16'h8002, 1, 1, 1'b0);

    cnn_busy = 1'b1;
    send_frame(16'h0001, 0, 1, 1'b0);
    cnn_busy = 1'b0;
    pay[0] = 16'h0BEE;
    send_frame(16'h0001, 1, 1, 1'b0);

    pay[0] = 16'h1111; pay[1] = 16'h2222;
    send_frame(16'h0002, 2, 21, 1'b0);

    for (int i = 0; i < 5; i++) pay[i] = 16'h5000 + 16'(i);
    send_frame(16'h0005, 2, 1, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("outputs_after_midframe_reset", 64'({mem_we, mem_sel, mem_addr, mem_wdata, busy, load_done, err, err_code}), 64'd0);
    repeat (TIMEOUT + 10) @(posedge clk);
    pay[0] = 16'hCAFE;
    send_frame(16'h0001, 1, 1, 1'b0);

    for (int f = 0; f < 30; f++) begin
      logic [15:0] hdr;
      int n;
      n = int'($urandom_range(0, 5));
      hdr = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 12'(n)};
      cnn_busy = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) pay[i] = 16'($urandom);
      send_frame(hdr, n, int'($urandom_range(1, 3)), 1'b0);
      cnn_busy = 1'b0;
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
